// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from vga_sync_gen: pixel counters plus delayed sync/video markers.
interface vga_sync_gen_if;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_start;
  logic       frame_start;

  modport master (
    output pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start
  );

  modport slave (
    input  pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: free-running pixel/line counters and a
// PIPE_DELAY-deep chain aligning sync/video markers with registered ROM data.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic           clk_25M,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int unsigned CNT_W      = 10;
  localparam int unsigned SB_W       = 5;
  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC - 1;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC - 1;
  localparam int unsigned LAST       = PIPE_DELAY - 1;

  // Chain stage layout {fs, ls, vis, vsync, hsync}; syncs stored at pin polarity.
  localparam logic [SB_W-1:0] INACT = {3'b000, ~SYNC_POL, ~SYNC_POL};

  logic [CNT_W-1:0] px_q, px_d;
  logic [CNT_W-1:0] py_q, py_d;
  logic [SB_W-1:0]  decode_c;
  logic [SB_W-1:0]  pipe_q [PIPE_DELAY];
  logic [SB_W-1:0]  pipe_d [PIPE_DELAY];
  logic             h_sync_c, v_sync_c, vis_c, ls_c, fs_c;

  // Horizontal counter wraps every line; vertical advances only on that wrap.
  always_comb begin
    px_d = px_q + CNT_W'(1);
    py_d = py_q;
    if (px_q == CNT_W'(H_TOTAL - 1)) begin
      px_d = '0;
      if (py_q == CNT_W'(V_TOTAL - 1)) begin
        py_d = '0;
      end else begin
        py_d = py_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    h_sync_c = (px_q >= CNT_W'(H_SYNC_BEG)) && (px_q <= CNT_W'(H_SYNC_END));
    v_sync_c = (py_q >= CNT_W'(V_SYNC_BEG)) && (py_q <= CNT_W'(V_SYNC_END));
    vis_c    = (px_q < CNT_W'(H_ACTIVE)) && (py_q < CNT_W'(V_ACTIVE));
    ls_c     = (px_q == '0);
    fs_c     = (px_q == '0) && (py_q == '0);
    decode_c = {fs_c, ls_c, vis_c,
                v_sync_c ? SYNC_POL : ~SYNC_POL,
                h_sync_c ? SYNC_POL : ~SYNC_POL};
  end

  always_comb begin
    pipe_d[0] = decode_c;
    for (int i = 1; i < int'(PIPE_DELAY); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_25M or posedge reset) begin
    if (reset) begin
      px_q <= '0;
      py_q <= '0;
      for (int i = 0; i < int'(PIPE_DELAY); i++) begin
        pipe_q[i] <= INACT;
      end
    end else begin
      px_q <= px_d;
      py_q <= py_d;
      for (int i = 0; i < int'(PIPE_DELAY); i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign vga.pixel_x     = px_q;
  assign vga.pixel_y     = py_q;
  assign vga.hsync       = pipe_q[LAST][0];
  assign vga.vsync       = pipe_q[LAST][1];
  assign vga.video_on    = pipe_q[LAST][2];
  assign vga.line_start  = pipe_q[LAST][3];
  assign vga.frame_start = pipe_q[LAST][4];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: four parameterisations against an arithmetic raster model,
// with randomized reset episodes and per-line / per-frame pulse tallies.
module tb_vga_sync_gen;

  logic clk;
  logic rst;
  int   t;
  int   n_cmp;
  int   n_bad;

  vga_sync_gen_if if0();
  vga_sync_gen_if if1();
  vga_sync_gen_if if2();
  vga_sync_gen_if if3();

  vga_sync_gen u_d0 (.clk_25M(clk), .reset(rst), .vga(if0));

  vga_sync_gen #(.SYNC_POL(1'b1), .PIPE_DELAY(1)) u_d1 (
    .clk_25M(clk), .reset(rst), .vga(if1));

  vga_sync_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                 .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(4),
                 .SYNC_POL(1'b1), .PIPE_DELAY(4)) u_d2 (
    .clk_25M(clk), .reset(rst), .vga(if2));

  vga_sync_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                 .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(4),
                 .SYNC_POL(1'b0), .PIPE_DELAY(2)) u_d3 (
    .clk_25M(clk), .reset(rst), .vga(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [24:0] p0, p1, p2, p3;
  assign p0 = {if0.pixel_x, if0.pixel_y, if0.hsync, if0.vsync, if0.video_on, if0.line_start, if0.frame_start};
  assign p1 = {if1.pixel_x, if1.pixel_y, if1.hsync, if1.vsync, if1.video_on, if1.line_start, if1.frame_start};
  assign p2 = {if2.pixel_x, if2.pixel_y, if2.hsync, if2.vsync, if2.video_on, if2.line_start, if2.frame_start};
  assign p3 = {if3.pixel_x, if3.pixel_y, if3.hsync, if3.vsync, if3.video_on, if3.line_start, if3.frame_start};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // Expected {x, y, hsync, vsync, video_on, line_start, frame_start} at cycle t after release.
  function automatic logic [24:0] model(input int tc, input bit r,
                                        input int ha, input int hf, input int hsw, input int hb,
                                        input int va, input int vf, input int vsw, input int vb,
                                        input bit pol, input int pd);
    int  ht, vt, x, y, ox, oy;
    bit  hreg, vreg, vis, ls, fs;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (r) return {10'd0, 10'd0, ~pol, ~pol, 3'b000};
    x = tc % ht;
    y = (tc / ht) % vt;
    if (tc < pd) return {10'(x), 10'(y), ~pol, ~pol, 3'b000};
    ox   = (tc - pd) % ht;
    oy   = ((tc - pd) / ht) % vt;
    hreg = (ox >= ha + hf) && (ox < ha + hf + hsw);
    vreg = (oy >= va + vf) && (oy < va + vf + vsw);
    vis  = (ox < ha) && (oy < va);
    ls   = (ox == 0);
    fs   = (ox == 0) && (oy == 0);
    return {10'(x), 10'(y), hreg ? pol : ~pol, vreg ? pol : ~pol, vis, ls, fs};
  endfunction

  task automatic check_all(input string ph);
    check_eq({ph, "/d0"}, 32'(p0), 32'(model(t, rst, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2)));
    check_eq({ph, "/d1"}, 32'(p1), 32'(model(t, rst, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1)));
    check_eq({ph, "/d2"}, 32'(p2), 32'(model(t, rst, 16, 4, 6, 6, 12, 2, 3, 4, 1'b1, 4)));
    check_eq({ph, "/d3"}, 32'(p3), 32'(model(t, rst, 16, 4, 6, 6, 12, 2, 3, 4, 1'b0, 2)));
  endtask

  // One clock: reset changes a few ns after the edge, outputs sampled on the falling edge.
  task automatic tick(input bit rst_next);
    @(posedge clk);
    if (!rst) t++;
    #($urandom_range(1, 3));
    if (rst_next && !rst) begin
      rst = 1'b1;
      #1;
      check_all("async");
    end else if (!rst_next && rst) begin
      rst = 1'b0;
      t   = 0;
    end
    @(negedge clk);
    check_all("cyc");
  endtask

  initial begin
    int hs_lo, vo_hi, first_lo;
    int fs3, ls3, vs3, vo3, hs3, vs2;
    n_cmp = 0;
    n_bad = 0;
    t     = 0;
    rst   = 1'b1;

    repeat (5) tick(1'b1);
    tick(1'b0);

    // One full default line of outputs, starting where the first line's outputs begin.
    while (t < 1) tick(1'b0);
    hs_lo = 0; vo_hi = 0; first_lo = -1;
    repeat (800) begin
      tick(1'b0);
      if (!if0.hsync) begin
        hs_lo++;
        if (first_lo < 0) first_lo = t;
      end
      if (if0.video_on) vo_hi++;
    end
    check_eq("line_hs_width", 32'(hs_lo), 32'd96);
    check_eq("line_hs_first", 32'(first_lo), 32'd658);
    check_eq("line_vo_count", 32'(vo_hi), 32'd640);

    // Any 672 consecutive output cycles of the small raster span exactly one frame.
    fs3 = 0; ls3 = 0; vs3 = 0; vo3 = 0; hs3 = 0; vs2 = 0;
    repeat (672) begin
      tick(1'b0);
      if (if3.frame_start) fs3++;
      if (if3.line_start)  ls3++;
      if (!if3.vsync)      vs3++;
      if (if3.video_on)    vo3++;
      if (!if3.hsync)      hs3++;
      if (if2.vsync)       vs2++;
    end
    check_eq("frm_fs", 32'(fs3), 32'd1);
    check_eq("frm_ls", 32'(ls3), 32'd21);
    check_eq("frm_vs", 32'(vs3), 32'd96);
    check_eq("frm_vo", 32'(vo3), 32'd192);
    check_eq("frm_hs", 32'(hs3), 32'd126);
    check_eq("frm_vs_pol1", 32'(vs2), 32'd96);

    // Mid-line reset while the default raster is inside hsync.
    while (t < 1500) tick(1'b0);
    check_eq("pre_rst_px", 32'(if0.pixel_x), 32'd700);
    check_eq("pre_rst_hs", 32'(if0.hsync), 32'd0);
    tick(1'b1);
    check_eq("rst_hs", 32'(if0.hsync), 32'd1);
    check_eq("rst_px", 32'(if0.pixel_x), 32'd0);
    tick(1'b0);
    tick(1'b0);
    check_eq("rel_d1_fs", 32'(if1.frame_start), 32'd1);
    check_eq("rel_d0_fs_early", 32'(if0.frame_start), 32'd0);
    tick(1'b0);
    check_eq("rel_d0_fs", 32'(if0.frame_start), 32'd1);
    check_eq("rel_d0_ls", 32'(if0.line_start), 32'd1);

    // Random run lengths punctuated by random-length resets.
    repeat (12) begin
      int n, r;
      n = int'($urandom_range(50, 3000));
      r = int'($urandom_range(1, 4));
      repeat (n) tick(1'b0);
      repeat (r) tick(1'b1);
      tick(1'b0);
    end
    repeat (20) tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA path, clocked by the 25 MHz pixel clock from the clock divider. It produces:
- horizontal and vertical pixel counters, used to address the image ROM;
- hsync, vsync, video_on and frame/line markers, delayed by a fixed number of cycles so they line up with the registered ROM data at the DAC/pins.

Default parameters give the standard 640x480@60 Hz mode (800 x 525 totals).

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 1'b0, asserted level of hsync/vsync (0 = active-low)
- PIPE_DELAY, 2, cycles from counter value to sync/video outputs; legal range 1..4

Ports:
- clk_25M  input  1  pixel clock from the clock divider
- reset  input  1  asynchronous, active-high reset
- pixel_x  output  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters)
- pixel_y  output  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = sum of the V parameters)
- hsync  output  1  horizontal sync, delayed by PIPE_DELAY
- vsync  output  1  vertical sync, delayed by PIPE_DELAY
- video_on  output  1  high in the visible region, delayed by PIPE_DELAY
- line_start  output  1  one-cycle pulse at pixel_x==0 of every line, delayed by PIPE_DELAY
- frame_start  output  1  one-cycle pulse at (0,0), delayed by PIPE_DELAY

## Operation
- **Horizontal counter.** pixel_x increments every clock. At H_TOTAL-1 (799) it wraps to 0.
- **Vertical counter.** pixel_y increments only in the cycle where pixel_x wraps. When pixel_y is V_TOTAL-1 (524) at that wrap, it returns to 0. Both counters wrap in the same edge at (799,524) -> (0,0).
- **Counter registers.** Both counters are registers, not decoded combinationally. Widths are fixed at 10 bits; parameters must keep H_TOTAL and V_TOTAL <= 1024.
- **Decode**, evaluated from the current counter values:
  - h_sync_region: pixel_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]
  - v_sync_region: pixel_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491]
  - vis: pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
  - ls: pixel_x == 0
  - fs: pixel_x == 0 and pixel_y == 0
- **Delay line.** The decode bits feed a PIPE_DELAY-deep register shift chain of 5 bits. The final stage drives the outputs:
  - hsync = h_sync_region ? SYNC_POL : ~SYNC_POL
  - vsync = v_sync_region ? SYNC_POL : ~SYNC_POL
  - video_on, line_start and frame_start driven directly by vis, ls and fs.
- **Combinational region.** Only the decode between the counters and the first delay stage is combinational. All outputs come straight from flops.
- **Reset values** (async assert, every output):
  - pixel_x = 0, pixel_y = 0
  - hsync = vsync = ~SYNC_POL (inactive)
  - video_on = 0, line_start = 0, frame_start = 0
  - every delay-chain stage holds the inactive pattern
- **Reset mid-frame.** Counters and the chain clear immediately on assertion. No partial pulse may appear after release beyond what the chain carries from post-release counter values.
- **No other state.** There is no enable input; the block runs every clk_25M cycle after reset release.

## Timing
- **Counter advance.** The first clk_25M rising edge after reset deasserts advances pixel_x from 0 to 1. The counter value (0,0) is therefore present for the cycle before that edge, labelled cycle 0.
- **Output latency.** For counter value (x,y) present in cycle N, the corresponding hsync/vsync/video_on/line_start/frame_start appear in cycle N+PIPE_DELAY. pixel_x/pixel_y carry no added latency.
- **First frame.** frame_start fires for the first frame after reset, in cycle PIPE_DELAY.
- **hsync width.** Exactly H_SYNC = 96 cycles per line, starting PIPE_DELAY cycles after pixel_x becomes 656.
- **vsync width.** Exactly V_SYNC*H_TOTAL = 1600 cycles per frame. It asserts and deasserts aligned with the (delayed) pixel_x==0 boundary.
- **Pulse widths.** line_start and frame_start are high for exactly one cycle each. frame_start coincides with a line_start.
- **Periods.** Line period 800 cycles; frame period 420000 cycles.
- **video_on.** High 640 consecutive cycles per visible line and for 480 lines. It is low for all of lines 480..524.

## Test plan
- **Reset release, PIPE_DELAY=2:** hold reset 5 cycles, release -> during reset all outputs at the reset values above (hsync=vsync=1). frame_start=1 and line_start=1 exactly in cycle 2, and low in cycles 1 and 3.
- **Horizontal line:** run one line -> pixel_x sweeps 0..799 then wraps to 0 with pixel_y 0->1. hsync low for exactly 96 cycles, first low cycle 658 cycles after pixel_x==0. video_on high 640 cycles.
- **Full frame:** run 420000 cycles -> exactly one frame_start, 525 line_start pulses, 1600 vsync-low cycles starting at line 490, 307200 video_on-high cycles. pixel_y wraps 524->0 in the same edge pixel_x wraps 799->0.
- **Mid-frame reset:** assert reset at pixel_x=700, pixel_y=300 (during hsync low) for 1 cycle -> hsync returns high asynchronously and counters read 0. After release the frame restarts with frame_start in cycle 2.
- **Parameter sweep:** PIPE_DELAY=1 and 4, and SYNC_POL=1 -> output latency is 1 and 4 cycles respectively. Sync pulses are active-high with unchanged widths and positions.
